// File: rtl/dbg_mem_arb.sv
// Arbiter for the shared synchronous memory port: a 2-entry debug FIFO has
// priority over the CPU, except while the CPU holds a bounded lock.
module dbg_mem_arb #(
  parameter int unsigned MAXLOCK = 8,
  parameter int unsigned FDEPTH  = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] c_addr,
  input  logic        c_r,
  input  logic [1:0]  c_wr,
  input  logic [15:0] c_wdata,
  input  logic        c_lock,
  output logic        c_ready,
  output logic [15:0] c_rdata,
  input  logic [15:0] u_addr,
  input  logic        u_r,
  input  logic [1:0]  u_wr,
  input  logic [15:0] u_wdata,
  output logic [15:0] u_rdata,
  output logic        u_valid,
  output logic        u_ovf,
  input  logic        u_ovf_clr,
  output logic        m_cs,
  output logic [15:0] m_addr,
  output logic        m_r,
  output logic [1:0]  m_wr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;
  localparam logic [1:0] FULL_CNT = 2'(FDEPTH);
  localparam logic [8:0] MAXLOCK_W = 9'(MAXLOCK);
  localparam logic       LOCK_EN  = (MAXLOCK > 32'd1);

  // entry layout: {addr[34:19], r[18], wr[17:16], wdata[15:0]}
  logic [34:0] fifo_mem_r [0:1];
  logic [34:0] head_s;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  cnt_r;
  logic        lock_active_r;
  logic [7:0]  lock_cnt_r;
  logic [8:0]  lock_cnt_inc_s;
  logic        u_ovf_r;
  logic [1:0]  rd_owner_r;
  logic [15:0] u_rdata_r;
  logic        c_cs_s;
  logic        u_cs_s;
  logic        fifo_ne_s;
  logic        fifo_full_s;
  logic        dbg_gnt_s;
  logic        cpu_gnt_s;
  logic        push_s;
  logic        pop_s;
  logic        ovf_set_s;

  assign c_cs_s      = |{c_wr, c_r};
  assign u_cs_s      = |{u_wr, u_r};
  assign fifo_ne_s   = (cnt_r != 2'd0);
  assign fifo_full_s = (cnt_r == FULL_CNT);
  assign head_s      = fifo_mem_r[rd_ptr_r];

  // Grant is gated by nreset so the memory strobes are quiet during reset.
  assign dbg_gnt_s = nreset & fifo_ne_s & ~lock_active_r;
  assign cpu_gnt_s = nreset & ~dbg_gnt_s & c_cs_s;
  assign pop_s     = dbg_gnt_s;
  assign push_s    = u_cs_s & (~fifo_full_s | pop_s);
  assign ovf_set_s = u_cs_s & fifo_full_s & ~pop_s;
  assign lock_cnt_inc_s = {1'b0, lock_cnt_r} + 9'd1;

  // Memory port mux driven by the current grant.
  always_comb begin
    m_addr  = 16'h0000;
    m_r     = 1'b0;
    m_wr    = 2'b00;
    m_wdata = 16'h0000;
    if (dbg_gnt_s) begin
      m_addr  = head_s[34:19];
      m_r     = head_s[18];
      m_wr    = head_s[17:16];
      m_wdata = head_s[15:0];
    end else if (cpu_gnt_s) begin
      m_addr  = c_addr;
      m_r     = c_r;
      m_wr    = c_wr;
      m_wdata = c_wdata;
    end else begin
      m_addr  = 16'h0000;
      m_r     = 1'b0;
      m_wr    = 2'b00;
      m_wdata = 16'h0000;
    end
  end

  assign m_cs    = |{m_r, m_wr};
  assign c_ready = cpu_gnt_s;
  assign c_rdata = m_rdata;

  // Debug FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fifo_mem_r[0] <= 35'd0;
      fifo_mem_r[1] <= 35'd0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      cnt_r         <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {u_addr, u_r, u_wr, u_wdata};
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow wins over a clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      u_ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      u_ovf_r <= 1'b1;
    end else if (u_ovf_clr) begin
      u_ovf_r <= 1'b0;
    end
  end

  // CPU lock tracking with forced release after MAXLOCK cycles.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lock_active_r <= 1'b0;
      lock_cnt_r    <= 8'd0;
    end else if (lock_active_r) begin
      if ((cpu_gnt_s && !c_lock) || !c_cs_s || (lock_cnt_inc_s >= MAXLOCK_W)) begin
        lock_active_r <= 1'b0;
        lock_cnt_r    <= 8'd0;
      end else begin
        lock_cnt_r    <= lock_cnt_inc_s[7:0];
      end
    end else if (cpu_gnt_s && c_lock) begin
      lock_active_r <= LOCK_EN;
      lock_cnt_r    <= LOCK_EN ? 8'd1 : 8'd0;
    end
  end

  // Read-return ownership and debug read data capture.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_owner_r <= OWN_NONE;
      u_rdata_r  <= 16'h0000;
    end else begin
      if (m_r) begin
        rd_owner_r <= dbg_gnt_s ? OWN_DBG : OWN_CPU;
      end else begin
        rd_owner_r <= OWN_NONE;
      end
      if (rd_owner_r == OWN_DBG) begin
        u_rdata_r <= m_rdata;
      end
    end
  end

  // Debug data is presented in the return cycle and held afterwards.
  assign u_valid = (rd_owner_r == OWN_DBG);
  assign u_rdata = u_valid ? m_rdata : u_rdata_r;
  assign u_ovf   = u_ovf_r;

endmodule

// File: tb/tb_dbg_mem_arb.sv
// Directed self-checking bench for dbg_mem_arb; the bench plays the memory
// by driving m_rdata in the cycle after each read.
module tb_dbg_mem_arb;

  logic        clk;
  logic        nreset;
  logic [15:0] c_addr;
  logic        c_r;
  logic [1:0]  c_wr;
  logic [15:0] c_wdata;
  logic        c_lock;
  logic        c_ready;
  logic [15:0] c_rdata;
  logic [15:0] u_addr;
  logic        u_r;
  logic [1:0]  u_wr;
  logic [15:0] u_wdata;
  logic [15:0] u_rdata;
  logic        u_valid;
  logic        u_ovf;
  logic        u_ovf_clr;
  logic        m_cs;
  logic [15:0] m_addr;
  logic        m_r;
  logic [1:0]  m_wr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  int n_chk;
  int n_pass;

  dbg_mem_arb #(.MAXLOCK(8), .FDEPTH(2)) dut (
    .clk(clk), .nreset(nreset),
    .c_addr(c_addr), .c_r(c_r), .c_wr(c_wr), .c_wdata(c_wdata),
    .c_lock(c_lock), .c_ready(c_ready), .c_rdata(c_rdata),
    .u_addr(u_addr), .u_r(u_r), .u_wr(u_wr), .u_wdata(u_wdata),
    .u_rdata(u_rdata), .u_valid(u_valid), .u_ovf(u_ovf), .u_ovf_clr(u_ovf_clr),
    .m_cs(m_cs), .m_addr(m_addr), .m_r(m_r), .m_wr(m_wr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    c_addr = 16'h0000; c_r = 1'b0; c_wr = 2'b00; c_wdata = 16'h0000; c_lock = 1'b0;
    u_addr = 16'h0000; u_r = 1'b0; u_wr = 2'b00; u_wdata = 16'h0000;
    u_ovf_clr = 1'b0; m_rdata = 16'h0000;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    c_r = 1'b1; c_addr = 16'h0042;
    #3;
    chk("rst_c_ready", c_ready, 1'b0);
    chk("rst_m_cs", m_cs, 1'b0);
    chk("rst_u_valid", u_valid, 1'b0);
    chk("rst_u_ovf", u_ovf, 1'b0);
    chk("rst_u_rdata", u_rdata, 16'h0000);
    nxt(); nxt();
    idle();
    nreset = 1'b1;
    nxt();

    // CPU-only read
    c_r = 1'b1; c_addr = 16'h0100;
    #1;
    chk("cpu_ready", c_ready, 1'b1);
    chk("cpu_m_r", m_r, 1'b1);
    chk("cpu_m_addr", m_addr, 16'h0100);
    nxt();
    c_r = 1'b0; m_rdata = 16'hBEEF;
    #1;
    chk("cpu_rdata", c_rdata, 16'hBEEF);
    chk("cpu_no_uvalid", u_valid, 1'b0);
    nxt();
    idle();

    // Debug write while CPU streams reads: push and CPU request on empty FIFO
    c_r = 1'b1; c_addr = 16'h0300;
    u_wr = 2'b10; u_addr = 16'h0201; u_wdata = 16'h00AA;
    #1;
    chk("dw_cpu_first", c_ready, 1'b1);
    nxt();
    u_wr = 2'b00; u_addr = 16'h0000; u_wdata = 16'h0000;
    #1;
    chk("dw_stall", c_ready, 1'b0);
    chk("dw_m_wr", m_wr, 2'b10);
    chk("dw_m_addr", m_addr, 16'h0201);
    chk("dw_m_wdata", m_wdata, 16'h00AA);
    chk("dw_m_r", m_r, 1'b0);
    nxt();
    #1;
    chk("dw_cpu_back", c_ready, 1'b1);
    chk("dw_cpu_addr", m_addr, 16'h0300);
    nxt();
    idle();
    nxt();

    // Debug read
    u_r = 1'b1; u_addr = 16'h0010;
    #1;
    chk("dr_no_grant_same", m_cs, 1'b0);
    nxt();
    u_r = 1'b0; u_addr = 16'h0000;
    #1;
    chk("dr_m_r", m_r, 1'b1);
    chk("dr_m_addr", m_addr, 16'h0010);
    chk("dr_uvalid_early", u_valid, 1'b0);
    nxt();
    m_rdata = 16'h1234;
    #1;
    chk("dr_uvalid", u_valid, 1'b1);
    chk("dr_urdata", u_rdata, 16'h1234);
    nxt();
    m_rdata = 16'h5555;
    #1;
    chk("dr_uvalid_pulse", u_valid, 1'b0);
    chk("dr_urdata_hold", u_rdata, 16'h1234);
    nxt();
    idle();

    // Back-to-back debug reads
    u_r = 1'b1; u_addr = 16'h0020;
    nxt();
    u_addr = 16'h0021;
    #1;
    chk("bb_m_addr0", m_addr, 16'h0020);
    nxt();
    u_r = 1'b0; u_addr = 16'h0000; m_rdata = 16'h1111;
    #1;
    chk("bb_m_addr1", m_addr, 16'h0021);
    chk("bb_uvalid0", u_valid, 1'b1);
    chk("bb_urdata0", u_rdata, 16'h1111);
    nxt();
    m_rdata = 16'h2222;
    #1;
    chk("bb_uvalid1", u_valid, 1'b1);
    chk("bb_urdata1", u_rdata, 16'h2222);
    nxt();
    m_rdata = 16'h0000;
    #1;
    chk("bb_uvalid_end", u_valid, 1'b0);
    nxt();

    // Lock held continuously with two debug accesses queued
    c_r = 1'b1; c_lock = 1'b1; c_addr = 16'h0400;
    #1;
    chk("lk_l0", c_ready, 1'b1);
    nxt();
    u_r = 1'b1; u_addr = 16'h0500;
    #1;
    chk("lk_l1", c_ready, 1'b1);
    nxt();
    u_r = 1'b0; u_wr = 2'b01; u_addr = 16'h0501; u_wdata = 16'h0033;
    #1;
    chk("lk_l2", c_ready, 1'b1);
    nxt();
    u_wr = 2'b00; u_addr = 16'h0000; u_wdata = 16'h0000;
    for (int k = 3; k < 8; k++) begin
      #1;
      chk("lk_hold", c_ready, 1'b1);
      nxt();
    end
    #1;
    chk("lk_rel_stall", c_ready, 1'b0);
    chk("lk_dbg0_r", m_r, 1'b1);
    chk("lk_dbg0_addr", m_addr, 16'h0500);
    nxt();
    m_rdata = 16'h7777;
    #1;
    chk("lk_dbg1_stall", c_ready, 1'b0);
    chk("lk_dbg1_wr", m_wr, 2'b01);
    chk("lk_dbg1_addr", m_addr, 16'h0501);
    chk("lk_dbg1_wdata", m_wdata, 16'h0033);
    chk("lk_dbg0_data", u_rdata, 16'h7777);
    nxt();
    m_rdata = 16'h0000;
    #1;
    chk("lk_cpu_again", c_ready, 1'b1);
    chk("lk_cpu_addr", m_addr, 16'h0400);
    chk("lk_no_ovf", u_ovf, 1'b0);
    nxt();
    idle();
    nxt();

    // Overflow during lock: third pulse dropped
    c_r = 1'b1; c_lock = 1'b1; c_addr = 16'h0600;
    nxt();
    u_r = 1'b1; u_addr = 16'h0700;
    nxt();
    u_addr = 16'h0701;
    nxt();
    u_addr = 16'h0702;
    #1;
    chk("ov_pre", u_ovf, 1'b0);
    nxt();
    u_r = 1'b0; u_addr = 16'h0000;
    #1;
    chk("ov_set", u_ovf, 1'b1);
    nxt(); nxt(); nxt(); nxt();
    #1;
    chk("ov_dbg0", m_addr, 16'h0700);
    chk("ov_dbg0_stall", c_ready, 1'b0);
    nxt();
    #1;
    chk("ov_dbg1", m_addr, 16'h0701);
    nxt();
    #1;
    chk("ov_cpu_back", c_ready, 1'b1);
    chk("ov_cpu_addr", m_addr, 16'h0600);
    chk("ov_sticky", u_ovf, 1'b1);
    nxt();
    idle();
    u_ovf_clr = 1'b1;
    #1;
    chk("ov_no_third", m_cs, 1'b0);
    nxt();
    u_ovf_clr = 1'b0;
    #1;
    chk("ov_cleared", u_ovf, 1'b0);
    nxt();

    // Reset mid-lock with a debug entry pending
    c_r = 1'b1; c_lock = 1'b1; c_addr = 16'h0800;
    nxt();
    u_r = 1'b1; u_addr = 16'h0900;
    nxt();
    u_r = 1'b0; u_addr = 16'h0000;
    #1;
    chk("rl_locked", c_ready, 1'b1);
    nreset = 1'b0;
    #1;
    chk("rl_c_ready", c_ready, 1'b0);
    chk("rl_m_cs", m_cs, 1'b0);
    chk("rl_m_r", m_r, 1'b0);
    chk("rl_u_valid", u_valid, 1'b0);
    nxt(); nxt();
    idle();
    nreset = 1'b1;
    #1;
    chk("rl_no_stale", m_cs, 1'b0);
    nxt();
    c_r = 1'b1; c_addr = 16'h0A00;
    #1;
    chk("rl_cpu_free", c_ready, 1'b1);
    chk("rl_cpu_addr", m_addr, 16'h0A00);
    nxt();
    idle();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
